// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address width, default sizes and the
// address type used by the pipeline hazard logic.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SB_W       = 32;
  localparam int unsigned CNT_W      = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // True when a valid write-back targets the given nonzero read address.
  function automatic logic reg_hit(input logic valid, input reg_addr_t wb_rd,
                                   input reg_addr_t rd);
    return valid && (wb_rd == rd) && (rd != '0);
  endfunction

endpackage

// File: rtl/regfile_sb_popcount.sv
// sb_popcount: combinational population count of the 32-bit scoreboard.
module sb_popcount
  import regfile_pkg::SB_W;
  import regfile_pkg::CNT_W;
(
  input  logic [SB_W-1:0]  sb_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < int'(SB_W); i++) begin
      cnt_o = cnt_o + CNT_W'(sb_i[i]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard.
// Optional write-back to read bypass when REGFILE_BYPASS_EN is defined.
module regfile_sb
  import regfile_pkg::reg_addr_t;
  import regfile_pkg::reg_hit;
  import regfile_pkg::SB_W;
  import regfile_pkg::CNT_W;
#(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  reg_addr_t         rs1_addr_i,
  input  reg_addr_t         rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  input  logic              issue_valid_i,
  input  reg_addr_t         issue_rd_i,
  input  logic              wb_valid_i,
  input  reg_addr_t         wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  busy_cnt_o
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [SB_W-1:0]   sb_q;
  logic [SB_W-1:0]   sb_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              wr_en;

  assign wr_en = wb_valid_i && (wb_rd_i != '0) && (32'(wb_rd_i) < NUM_REGS);

  // Data array; x0 is never written so it stays 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wb_rd_i] <= wb_data_i;
    end
  end

  // Next scoreboard: write-back clears, issue sets (set wins), flush clears all.
  always_comb begin
    sb_d = sb_q;
    if (wb_valid_i) begin
      sb_d[wb_rd_i] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != '0)) begin
      sb_d[issue_rd_i] = 1'b1;
    end
    if (flush_i) begin
      sb_d = '0;
    end
    sb_d[0] = 1'b0;
  end

  sb_popcount u_popcount (
    .sb_i  (sb_d),
    .cnt_o (cnt_d)
  );

  // Count is taken from the next-state bits so it moves with the scoreboard.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q       <= '0;
      busy_cnt_o <= '0;
    end else begin
      sb_q       <= sb_d;
      busy_cnt_o <= cnt_d;
    end
  end

  // Read ports; forced to 0 during reset so a bypass cannot leak through.
  always_comb begin
    rs1_data_o = '0;
    rs1_busy_o = 1'b0;
    rs2_data_o = '0;
    rs2_busy_o = 1'b0;
    if (!rst_i && (rs1_addr_i != '0) && (32'(rs1_addr_i) < NUM_REGS)) begin
      rs1_data_o = regs[rs1_addr_i];
      rs1_busy_o = sb_q[rs1_addr_i];
`ifdef REGFILE_BYPASS_EN
      if (reg_hit(wb_valid_i, wb_rd_i, rs1_addr_i)) begin
        rs1_data_o = wb_data_i;
        rs1_busy_o = 1'b0;
      end
`endif
    end
    if (!rst_i && (rs2_addr_i != '0) && (32'(rs2_addr_i) < NUM_REGS)) begin
      rs2_data_o = regs[rs2_addr_i];
      rs2_busy_o = sb_q[rs2_addr_i];
`ifdef REGFILE_BYPASS_EN
      if (reg_hit(wb_valid_i, wb_rd_i, rs2_addr_i)) begin
        rs2_data_o = wb_data_i;
        rs2_busy_o = 1'b0;
      end
`endif
    end
  end

endmodule
